// File: rtl/uart_rx_seq.sv
// uart_rx_seq: re-arms the single-byte UART shift register after every byte or idle miss.
// Packs received bytes big-endian into words. Define RXSEQ_TIMEOUT_EN to flush stale partial words.
module uart_rx_seq #(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned ERRCNT_W   = 8
`ifdef RXSEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT    = 64
`endif
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  output logic                    o_Sr_Rst_n,
  input  logic [7:0]              i_Sr_Byte,
  input  logic                    i_Sr_Ok,
  input  logic                    i_Sr_Error,
  output logic [8*WORD_BYTES-1:0] o_Word,
  output logic                    o_Word_Valid,
  input  logic                    i_Word_Ready,
  output logic                    o_Frame_Err,
  output logic                    o_Overrun,
  output logic [ERRCNT_W-1:0]     o_Err_Cnt
`ifdef RXSEQ_TIMEOUT_EN
  ,
  output logic                    o_Timeout
`endif
);

  localparam int unsigned WORD_W = 8 * WORD_BYTES;
  localparam int unsigned IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned AGE_W  = 4;
`ifdef RXSEQ_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
`endif

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    LISTEN  = 2'd1,
    HARVEST = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [AGE_W-1:0]    r_age, w_age_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [WORD_W-1:0]   r_asm, w_asm_nxt;
  logic [WORD_W-1:0]   r_word, w_word_nxt;
  logic [WORD_W-1:0]   w_filled;
  logic                r_valid, w_valid_nxt;
  logic                r_frame_err, w_frame_err_nxt;
  logic                r_overrun, w_overrun_nxt;
  logic [ERRCNT_W-1:0] r_err_cnt, w_err_cnt_nxt;
  logic                w_err_inc;
  logic                r_sr_rst_n, w_sr_rst_n_nxt;
`ifdef RXSEQ_TIMEOUT_EN
  logic [IDLE_W-1:0]   r_idle, w_idle_nxt;
  logic                r_timeout, w_timeout_nxt;
`endif

  // State register
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) r_state <= ARM;
    else          r_state <= w_state_nxt;
  end

  // Next state, datapath next values and output pulses
  always_comb begin
    w_state_nxt     = r_state;
    w_age_nxt       = r_age;
    w_idx_nxt       = r_idx;
    w_asm_nxt       = r_asm;
    w_word_nxt      = r_word;
    w_valid_nxt     = r_valid;
    w_filled        = r_asm;
    w_frame_err_nxt = 1'b0;
    w_overrun_nxt   = 1'b0;
    w_err_inc       = 1'b0;
`ifdef RXSEQ_TIMEOUT_EN
    w_idle_nxt      = r_idle;
    w_timeout_nxt   = 1'b0;
`endif

    if (r_valid && i_Word_Ready) w_valid_nxt = 1'b0;

    case (r_state)
      ARM: begin
        w_age_nxt   = '0;
        w_state_nxt = LISTEN;
      end
      LISTEN: begin
        if (r_age != '1) w_age_nxt = r_age + AGE_W'(1);
        if (i_Sr_Error && (r_age == AGE_W'(1))) begin
          w_state_nxt = ARM;
        end else if (i_Sr_Error && (r_age >= AGE_W'(2))) begin
          w_frame_err_nxt = 1'b1;
          w_err_inc       = 1'b1;
          w_state_nxt     = ARM;
        end else if (i_Sr_Ok && (r_age >= AGE_W'(10))) begin
          w_state_nxt = HARVEST;
        end
`ifdef RXSEQ_TIMEOUT_EN
        // Partial word has gone stale: drop it silently
        if (r_idx != '0) begin
          if (r_idle == IDLE_W'(TIMEOUT - 1)) begin
            w_idle_nxt    = '0;
            w_idx_nxt     = '0;
            w_asm_nxt     = '0;
            w_timeout_nxt = 1'b1;
          end else begin
            w_idle_nxt = r_idle + IDLE_W'(1);
          end
        end
`endif
      end
      HARVEST: begin
        for (int i = 0; i < WORD_BYTES; i++) begin
          if (r_idx == IDX_W'(i)) w_filled[WORD_W-1-8*i -: 8] = i_Sr_Byte;
        end
        if (r_idx == IDX_W'(WORD_BYTES - 1)) begin
          w_idx_nxt = '0;
          w_asm_nxt = '0;
          if (!r_valid || i_Word_Ready) begin
            w_word_nxt  = w_filled;
            w_valid_nxt = 1'b1;
          end else begin
            w_overrun_nxt = 1'b1;
            w_err_inc     = 1'b1;
          end
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
          w_asm_nxt = w_filled;
        end
        w_state_nxt = ARM;
`ifdef RXSEQ_TIMEOUT_EN
        w_idle_nxt  = '0;
`endif
      end
      default: w_state_nxt = ARM;
    endcase

    w_err_cnt_nxt  = (w_err_inc && (r_err_cnt != '1)) ? r_err_cnt + ERRCNT_W'(1) : r_err_cnt;
    w_sr_rst_n_nxt = (w_state_nxt != ARM);
  end

  // Datapath and output registers
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_age       <= '0;
      r_idx       <= '0;
      r_asm       <= '0;
      r_word      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_err_cnt   <= '0;
      r_sr_rst_n  <= 1'b0;
`ifdef RXSEQ_TIMEOUT_EN
      r_idle      <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_age       <= w_age_nxt;
      r_idx       <= w_idx_nxt;
      r_asm       <= w_asm_nxt;
      r_word      <= w_word_nxt;
      r_valid     <= w_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_overrun   <= w_overrun_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_sr_rst_n  <= w_sr_rst_n_nxt;
`ifdef RXSEQ_TIMEOUT_EN
      r_idle      <= w_idle_nxt;
      r_timeout   <= w_timeout_nxt;
`endif
    end
  end

  assign o_Sr_Rst_n   = r_sr_rst_n;
  assign o_Word       = r_word;
  assign o_Word_Valid = r_valid;
  assign o_Frame_Err  = r_frame_err;
  assign o_Overrun    = r_overrun;
  assign o_Err_Cnt    = r_err_cnt;
`ifdef RXSEQ_TIMEOUT_EN
  assign o_Timeout    = r_timeout;
`endif

endmodule

// File: tb/tb_uart_rx_seq.sv
// Self-checking bench for uart_rx_seq: a behavioural UART shift register feeds the DUT,
// and a byte/word-level reference model predicts words, errors and counters.
`timescale 1ns/1ps
module tb_uart_rx_seq;

  localparam int unsigned WB      = 4;
  localparam int unsigned EW      = 8;
  localparam int unsigned ERR_MAX = (1 << EW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sr_rst_n;
  logic [7:0]        sr_byte;
  logic              sr_ok, sr_err;
  logic [8*WB-1:0]   word;
  logic              word_valid;
  logic              word_ready = 1'b1;
  logic              frame_err, overrun;
  logic [EW-1:0]     err_cnt;
  logic              rx = 1'b1;
`ifdef RXSEQ_TIMEOUT_EN
  logic              timeout;
`endif

  uart_rx_seq #(.WORD_BYTES(WB), .ERRCNT_W(EW)) dut (
    .i_Clk        (clk),
    .i_Reset      (rst_n),
    .o_Sr_Rst_n   (sr_rst_n),
    .i_Sr_Byte    (sr_byte),
    .i_Sr_Ok      (sr_ok),
    .i_Sr_Error   (sr_err),
    .o_Word       (word),
    .o_Word_Valid (word_valid),
    .i_Word_Ready (word_ready),
    .o_Frame_Err  (frame_err),
    .o_Overrun    (overrun),
    .o_Err_Cnt    (err_cnt)
`ifdef RXSEQ_TIMEOUT_EN
    ,
    .o_Timeout    (timeout)
`endif
  );

  always #5 clk = ~clk;

  // External UART shift register: start bit, 8 data bits LSB first, stop bit; sticky flags
  logic [3:0] sr_cnt;
  always @(posedge clk or negedge sr_rst_n) begin
    if (!sr_rst_n) begin
      sr_cnt  <= 4'd0;
      sr_byte <= 8'd0;
      sr_ok   <= 1'b0;
      sr_err  <= 1'b0;
    end else if (!sr_ok && !sr_err) begin
      if (sr_cnt == 4'd0) begin
        if (rx) sr_err <= 1'b1;
        else    sr_cnt <= 4'd1;
      end else if (sr_cnt <= 4'd8) begin
        sr_byte[sr_cnt - 4'd1] <= rx;
        sr_cnt <= sr_cnt + 4'd1;
      end else begin
        if (rx) sr_ok  <= 1'b1;
        else    sr_err <= 1'b1;
      end
    end
  end

  // Monitor: accepted words and pulse counts, sampled mid-cycle
  logic [8*WB-1:0] got_q[$];
  int fe_cnt = 0, ov_cnt = 0, to_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (word_valid && word_ready) got_q.push_back(word);
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
`ifdef RXSEQ_TIMEOUT_EN
      if (timeout)   to_cnt++;
`endif
    end
  end

  // Reference model at frame/word level
  logic [7:0]      m_part[$];
  logic [8*WB-1:0] exp_q[$];
  logic [8*WB-1:0] m_word = '0;
  bit              m_valid = 1'b0;
  int              m_err = 0, m_fe = 0, m_ov = 0;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic err_add();
    if (m_err < int'(ERR_MAX)) m_err++;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good);
    logic [8*WB-1:0] w;
    if (!good) begin
      m_fe++;
      err_add();
    end else begin
      m_part.push_back(b);
      if (m_part.size() == WB) begin
        w = '0;
        foreach (m_part[i]) w = (w << 8) | (8*WB)'(m_part[i]);
        m_part.delete();
        if (word_ready)    exp_q.push_back(w);
        else if (!m_valid) begin m_word = w; m_valid = 1'b1; end
        else begin m_ov++; err_add(); end
      end
    end
  endtask

  task automatic wait_arm(input string tag);
    int n = 0;
    while (sr_rst_n !== 1'b0 && n < 64) begin tick(); n++; end
    if (sr_rst_n !== 1'b0) check(tag, sr_rst_n, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good, input int gap);
    wait_arm("arm_wait");
    tick(); rx = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); rx = b[i]; end
    tick(); rx = good;
    tick(); rx = 1'b1;
    repeat (gap) tick();
    model_frame(b, good);
  endtask

  task automatic compare_words(input string tag);
    int n;
    repeat (6) tick();
    check({tag, "_nwords"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_word"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    check({tag, "_errcnt"}, err_cnt, m_err);
    check({tag, "_frame_err"}, fe_cnt, m_fe);
    check({tag, "_overrun"}, ov_cnt, m_ov);
  endtask

  task automatic flush_partial();
    while (m_part.size() != 0) send_frame(8'($urandom), 1'b1, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lows, run, maxrun, consec, n, to0;
    logic [7:0] b;
    bit good;

    repeat (3) tick();
    check("rst_sr_rst_n", sr_rst_n, 1'b0);
    check("rst_word", word, '0);
    check("rst_valid", word_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_errcnt", err_cnt, '0);
    rst_n = 1'b1;

    // Idle line: one-cycle re-arm pulse every loop, nothing reported
    lows = 0; run = 0; maxrun = 0;
    repeat (50) begin
      tick();
      if (!sr_rst_n) begin
        lows++; run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
    end
    check("idle_arm_count_ge16", lows >= 16, 1'b1);
    check("idle_arm_width", maxrun, 1);
    check("idle_valid", word_valid, 1'b0);
    compare_words("idle");

    // Fixed word, big-endian
    send_frame(8'h61, 1'b1, 2);
    send_frame(8'h62, 1'b1, 2);
    send_frame(8'h63, 1'b1, 2);
    send_frame(8'h64, 1'b1, 2);
    repeat (6) tick();
    check("fixed_word_value", got_q.size() > 0 ? got_q[0] : '0, 32'h61626364);
    compare_words("fixed");

    // Framing error does not disturb the partial word
    send_frame(8'hA5, 1'b0, 2);
    repeat (4) tick();
    check("ferr_errcnt", err_cnt, 1);
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1, 2);
    compare_words("ferr");

    // Random mix of good and bad frames
    consec = 0;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      good = !(($urandom_range(0, 3) == 0) && (consec < 2));
      consec = good ? 0 : consec + 1;
      send_frame(b, good, $urandom_range(0, 3));
    end
    flush_partial();
    compare_words("rand");

    // Consumer stalled: first word held, second dropped
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_frame(8'($urandom), 1'b1, 1);
    repeat (6) tick();
    check("stall_word_held", word, m_word);
    check("stall_valid", word_valid, m_valid);
    check("stall_overrun", ov_cnt, m_ov);
    check("stall_errcnt", err_cnt, m_err);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    exp_q.push_back(m_word);
    m_valid = 1'b0;
    check("stall_release_valid", word_valid, 1'b0);
    word_ready = 1'b1;
    compare_words("stall");

    // Error counter saturation
    for (int i = 0; i < 256; i++) send_frame(8'($urandom), 1'b0, 0);
    compare_words("sat");
    check("sat_errcnt_max", err_cnt, ERR_MAX);

    // Asynchronous reset during data bit 4
    b = 8'($urandom);
    wait_arm("arm_wait_rst");
    tick(); rx = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); rx = b[i]; end
    #2 rst_n = 1'b0;
    #1;
    check("amid_sr_rst_n", sr_rst_n, 1'b0);
    check("amid_word", word, '0);
    check("amid_valid", word_valid, 1'b0);
    check("amid_frame_err", frame_err, 1'b0);
    check("amid_overrun", overrun, 1'b0);
    check("amid_errcnt", err_cnt, '0);
    repeat (2) tick();
    rx = 1'b1;
    rst_n = 1'b1;
    m_part.delete();
    m_err = 0;
    m_valid = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1, 2);
    compare_words("post_rst");

`ifdef RXSEQ_TIMEOUT_EN
    // Stale partial word is flushed without touching the error counter
    to0 = to_cnt;
    send_frame(8'($urandom), 1'b1, 2);
    send_frame(8'($urandom), 1'b1, 2);
    n = 0;
    while (to_cnt == to0 && n < 400) begin tick(); n++; end
    repeat (10) tick();
    check("timeout_pulses", to_cnt - to0, 1);
    m_part.delete();
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1, 2);
    compare_words("timeout");
`else
    to0 = 0;
    n = 0;
    check("no_timeout_count", to_cnt, to0 + n);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_seq.md
Name: uart_rx_seq

Overview:
- Sequencer for the single-byte UART receive shift register, which needs a reset between bytes.
- Owns that shift register's active-low reset and re-arms it after every byte or idle miss.
- Harvests received bytes and packs WORD_BYTES of them, big-endian, into words for the SHA-256 message loader.
- Runs on the same baud-rate Clk as the shift register; Rx is sampled once per Clk.

Parameters:
- WORD_BYTES, 4, bytes packed per output word (1..8).
- ERRCNT_W, 8, width of the saturating frame-error counter.
- TIMEOUT, 64, idle cycles before a partial word is flushed (only with RXSEQ_TIMEOUT_EN).

Ports:
- Clk  in  1  baud-rate clock.
- Reset  in  1  asynchronous, active-low reset.
- Sr_Rst_n  out  1  active-low reset to the shift register; registered, never combinational.
- Sr_Byte  in  8  received byte from the shift register.
- Sr_Ok  in  1  shift register stop bit good (sticky until Sr_Rst_n).
- Sr_Error  in  1  shift register error (sticky until Sr_Rst_n).
- Word  out  8*WORD_BYTES  packed word; first received byte in the MSBs.
- Word_Valid  out  1  Word holds unread data.
- Word_Ready  in  1  consumer accepts Word when Valid&Ready at the posedge.
- Frame_Err  out  1  one-cycle pulse on a stop-bit error.
- Overrun  out  1  one-cycle pulse when a completed word is dropped.
- Err_Cnt  out  ERRCNT_W  saturating count of frame errors plus overruns.

Behaviour:
- Reset values: Sr_Rst_n=0, Word=0, Word_Valid=0, Frame_Err=0, Overrun=0, Err_Cnt=0, byte index=0, assembly register=0, state=ARM.
- States:
  - ARM: drive Sr_Rst_n=0 for exactly one cycle, clear the age counter, go to LISTEN.
  - LISTEN: Sr_Rst_n=1; the age counter increments each cycle.
    - Sr_Error with age==1 means no start bit (idle line): go to ARM, no error reported.
    - Sr_Ok with age>=10 means a good byte: go to HARVEST.
    - Sr_Error with age>=2 means a framing error: pulse Frame_Err, increment Err_Cnt, discard Sr_Byte, go to ARM. The partial word is kept.
  - HARVEST (1 cycle): write Sr_Byte into assembly slot byte_idx and increment byte_idx. When byte_idx reaches WORD_BYTES-1 the word is complete; then go to ARM.
- A start bit that falls on the ARM cycle is lost. This is a known, accepted limitation; the host inserts idle between bytes.
- A good byte takes 11 cycles from release: 1 start, 8 data, 1 stop, 1 harvest, plus 1 ARM cycle to re-arm.
- Word completion:
  - If Word_Valid=0, or Word_Ready=1 in the same cycle: load Word, set Word_Valid=1 on the next cycle, clear assembly and byte_idx.
  - Otherwise drop the word: pulse Overrun, increment Err_Cnt, clear assembly and byte_idx. The held Word is untouched.
- Handshake:
  - Word_Valid clears when Valid&Ready.
  - Word is stable while Valid=1 and Ready=0.
  - A simultaneous accept and completion keeps Word_Valid=1 and loads the new word.
- Err_Cnt saturates at all ones and does not wrap. If a frame error and an overrun coincide, it adds 1 only (they cannot coincide per the FSM, but this rule is required).
- Reset asserted mid-byte: everything returns to reset values immediately and asynchronously. Sr_Rst_n drops asynchronously with it.
- Illegal state encodings recover to ARM.

Optional Feature:
- Macro: RXSEQ_TIMEOUT_EN.
- Defined:
  - An idle counter counts cycles in LISTEN while byte_idx!=0. It resets on every HARVEST.
  - On reaching TIMEOUT, the partial word is discarded (assembly and byte_idx cleared), with no Err_Cnt change.
  - An extra output, Timeout (1 bit, reset 0), pulses for one cycle.
- Undefined: no idle counter, no Timeout port; partial words are held indefinitely.

Test Plan:
- Idle line (Rx=1 feeding the shift register) for 50 cycles -> Sr_Rst_n pulses low every ARM/LISTEN loop; no Frame_Err, Word_Valid=0, Err_Cnt=0.
- Send bytes 0x61,0x62,0x63,0x64 with 2 idle cycles between each, Word_Ready=1 -> one Word_Valid pulse with Word=0x61626364, Err_Cnt=0.
- Byte 0xA5 with stop bit 0 -> Frame_Err pulses once, Err_Cnt=1, byte_idx unchanged. Then send 4 good bytes -> Word contains only the 4 good bytes.
- Word_Ready=0, send 8 good bytes -> first word held unchanged, second word dropped with Overrun=1, Err_Cnt=1. Then Ready=1 for one cycle -> Word_Valid=0.
- Drive Err_Cnt to 255 via 256 framing errors -> stays 255.
- Assert Reset during data bit 4 -> all outputs go to reset values immediately. After release, 4 fresh bytes produce a correct word. With RXSEQ_TIMEOUT_EN: send 2 bytes, idle 64 cycles -> Timeout pulse, next 4 bytes form a clean word.
